// File: rtl/hps_reset_request_gen.sv
// Turns debounced push-button gestures into one-hot, level-held HPS reset requests
// (cold on long press, warm on short press, debug on long dual-button press).
module hps_reset_request_gen #(
   parameter int unsigned SHORT_MIN = 5_000_000,
   parameter int unsigned LONG_MIN  = 100_000_000,
   parameter int unsigned CNT_WIDTH = 27,
   parameter int unsigned REQ_HOLD  = 16,
   parameter int unsigned COOLDOWN  = 2_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] btn_n,
   output logic [2:0] hps_reset_req,
   output logic       busy,
   output logic [2:0] last_req,
   output logic [7:0] req_count
);

   localparam int unsigned HOLD_W = $clog2(REQ_HOLD);
   localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_PRESS        = 3'd1;
   localparam logic [2:0] ST_ISSUE        = 3'd2;
   localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
   localparam logic [2:0] ST_COOLDOWN     = 3'd4;

   localparam logic [2:0] REQ_COLD  = 3'b001;
   localparam logic [2:0] REQ_WARM  = 3'b010;
   localparam logic [2:0] REQ_DEBUG = 3'b100;

   logic [2:0]           state, state_d;
   logic [CNT_WIDTH-1:0] cnt, cnt_d, cnt_inc;
   logic                 dual_f, dual_f_d;
   logic [HOLD_W-1:0]    hold_cnt, hold_cnt_d;
   logic [COOL_W-1:0]    cool_cnt, cool_cnt_d;
   logic [2:0]           req_d, last_req_d;
   logic [7:0]           req_count_d;
   logic                 busy_d;
   logic                 pressed, dual;
   logic                 issue;
   logic [2:0]           issue_req;

   assign pressed = |(~btn_n);
   assign dual    = &(~btn_n);
   assign cnt_inc = cnt + CNT_WIDTH'(1);

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         dual_f        <= 1'b0;
         hold_cnt      <= '0;
         cool_cnt      <= '0;
         hps_reset_req <= '0;
         busy          <= 1'b0;
         last_req      <= '0;
         req_count     <= '0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         dual_f        <= dual_f_d;
         hold_cnt      <= hold_cnt_d;
         cool_cnt      <= cool_cnt_d;
         hps_reset_req <= req_d;
         busy          <= busy_d;
         last_req      <= last_req_d;
         req_count     <= req_count_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      dual_f_d    = dual_f;
      hold_cnt_d  = hold_cnt;
      cool_cnt_d  = cool_cnt;
      req_d       = hps_reset_req;
      last_req_d  = last_req;
      req_count_d = req_count;
      issue       = 1'b0;
      issue_req   = REQ_WARM;

      case (state)
         ST_IDLE: begin
            if (enable && pressed) begin
               state_d  = ST_PRESS;
               cnt_d    = CNT_WIDTH'(1);
               dual_f_d = dual;
            end
         end
         ST_PRESS: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (pressed) begin
               cnt_d    = (cnt == CNT_WIDTH'(LONG_MIN)) ? cnt : cnt_inc;
               dual_f_d = dual_f | dual;
               if (cnt_inc == CNT_WIDTH'(LONG_MIN)) begin
                  issue     = 1'b1;
                  issue_req = (dual_f | dual) ? REQ_DEBUG : REQ_COLD;
               end
            end else if (cnt < CNT_WIDTH'(SHORT_MIN)) begin
               state_d = ST_IDLE;
            end else if (!dual_f) begin
               issue     = 1'b1;
               issue_req = REQ_WARM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (hold_cnt == HOLD_W'(REQ_HOLD - 1)) begin
               state_d = ST_WAIT_RELEASE;
               req_d   = '0;
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         ST_WAIT_RELEASE: begin
            if (!pressed) begin
               state_d    = ST_COOLDOWN;
               cool_cnt_d = '0;
            end
         end
         ST_COOLDOWN: begin
            // Any press restarts the quiet window
            if (pressed) begin
               cool_cnt_d = '0;
            end else if (cool_cnt == COOL_W'(COOLDOWN - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cool_cnt_d = cool_cnt + COOL_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = '0;
         end
      endcase

      if (issue) begin
         state_d     = ST_ISSUE;
         hold_cnt_d  = '0;
         req_d       = issue_req;
         last_req_d  = issue_req;
         req_count_d = req_count + 8'd1;
      end

      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_hps_reset_request_gen.sv
// Self-checking bench for hps_reset_request_gen: table of press gestures plus
// hand-written cooldown-restart and mid-request reset sequences.
module tb_hps_reset_request_gen;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [1:0] btn_n;
   logic [2:0] hps_reset_req;
   logic       busy;
   logic [2:0] last_req;
   logic [7:0] req_count;

   int checks = 0;
   int errors = 0;

   hps_reset_request_gen #(
      .SHORT_MIN(4),
      .LONG_MIN (20),
      .CNT_WIDTH(5),
      .REQ_HOLD (3),
      .COOLDOWN (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .btn_n        (btn_n),
      .hps_reset_req(hps_reset_req),
      .busy         (busy),
      .last_req     (last_req),
      .req_count    (req_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] btn_a;      // buttons at start of press
      logic [1:0] btn_b;      // buttons from press cycle sw onward
      int         sw;         // 0 = no switch
      int         len;        // press length in cycles
      int         en_off;     // press cycle where enable drops, 0 = never
      logic [2:0] exp_req;    // expected request value, 0 = none
      int         exp_first;  // cycle index after which request is first seen
      int         exp_idle;   // first cycle after release with busy low
      int         exp_count;
      logic [2:0] exp_last;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs[NVEC];

   int         first_k, hi_cnt, idle_k, multi;
   logic [2:0] seen_req;
   logic [1:0] b;
   logic       e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs change at negedge; outputs are read at the following negedge
   task automatic tick(input logic [1:0] bv, input logic ev, input logic rv);
      btn_n  = bv;
      enable = ev;
      rst    = rv;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      //          btn_a  btn_b  sw len en  req     first idle cnt last
      vecs[0]  = '{2'b10, 2'b10, 0,  2, 0, 3'b000, 0,    3,  0, 3'b000};
      vecs[1]  = '{2'b10, 2'b10, 0,  3, 0, 3'b000, 0,    4,  0, 3'b000};
      vecs[2]  = '{2'b10, 2'b10, 0,  4, 0, 3'b010, 5,   14,  1, 3'b010};
      vecs[3]  = '{2'b10, 2'b10, 0, 10, 0, 3'b010, 11,  20,  2, 3'b010};
      vecs[4]  = '{2'b01, 2'b01, 0, 30, 0, 3'b001, 20,  36,  3, 3'b001};
      vecs[5]  = '{2'b00, 2'b00, 0, 25, 0, 3'b100, 20,  31,  4, 3'b100};
      vecs[6]  = '{2'b00, 2'b00, 0, 10, 0, 3'b000, 0,   11,  4, 3'b100};
      vecs[7]  = '{2'b10, 2'b00, 4, 10, 0, 3'b000, 0,   11,  4, 3'b100};
      vecs[8]  = '{2'b10, 2'b10, 0, 19, 0, 3'b010, 20,  29,  5, 3'b010};
      vecs[9]  = '{2'b10, 2'b10, 0, 20, 0, 3'b001, 20,  29,  6, 3'b001};
      vecs[10] = '{2'b10, 2'b10, 0, 10, 6, 3'b000, 0,   11,  6, 3'b001};
      vecs[11] = '{2'b01, 2'b00, 15, 25, 0, 3'b100, 20, 31,  7, 3'b100};

      btn_n  = 2'b11;
      enable = 1'b1;
      rst    = 1'b1;
      @(negedge clk);
      tick(2'b11, 1'b1, 1'b1);
      tick(2'b11, 1'b1, 1'b1);
      check("reset req",   32'(hps_reset_req), 32'd0);
      check("reset busy",  32'(busy),          32'd0);
      check("reset last",  32'(last_req),      32'd0);
      check("reset count", 32'(req_count),     32'd0);
      tick(2'b11, 1'b1, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         first_k  = 0;
         hi_cnt   = 0;
         idle_k   = 0;
         multi    = 0;
         seen_req = '0;
         for (int k = 1; k <= 100 && idle_k == 0; k++) begin
            if (k <= vecs[i].len) begin
               b = (vecs[i].sw != 0 && k >= vecs[i].sw) ? vecs[i].btn_b : vecs[i].btn_a;
               e = !(vecs[i].en_off != 0 && k >= vecs[i].en_off);
            end else begin
               b = 2'b11;
               e = 1'b1;
            end
            tick(b, e, 1'b0);
            if (hps_reset_req != 3'b000) begin
               if (first_k == 0) first_k = k;
               seen_req = seen_req | hps_reset_req;
               hi_cnt++;
               if ($countones(hps_reset_req) > 1) multi = 1;
            end
            if (k > vecs[i].len && busy == 1'b0) idle_k = k;
         end
         check($sformatf("v%0d req", i),    32'(seen_req), 32'(vecs[i].exp_req));
         check($sformatf("v%0d first", i),  32'(first_k),  32'(vecs[i].exp_first));
         check($sformatf("v%0d hold", i),   32'(hi_cnt),   (vecs[i].exp_req != 3'b000) ? 32'd3 : 32'd0);
         check($sformatf("v%0d idle", i),   32'(idle_k),   32'(vecs[i].exp_idle));
         check($sformatf("v%0d count", i),  32'(req_count), 32'(vecs[i].exp_count));
         check($sformatf("v%0d last", i),   32'(last_req),  32'(vecs[i].exp_last));
         check($sformatf("v%0d onehot", i), 32'(multi),     32'd0);
         tick(2'b11, 1'b1, 1'b0);
      end

      // Press during cooldown restarts the quiet window
      for (int k = 1; k <= 6; k++) tick(2'b10, 1'b1, 1'b0);
      tick(2'b11, 1'b1, 1'b0);
      check("cool req", 32'(hps_reset_req), 32'(3'b010));
      for (int k = 8; k <= 13; k++) tick(2'b11, 1'b1, 1'b0);
      check("cool busy13", 32'(busy), 32'd1);
      tick(2'b10, 1'b1, 1'b0);
      for (int k = 15; k <= 18; k++) tick(2'b11, 1'b1, 1'b0);
      check("cool busy18", 32'(busy), 32'd1);
      check("cool noreq", 32'(hps_reset_req), 32'd0);
      tick(2'b11, 1'b1, 1'b0);
      check("cool busy19", 32'(busy), 32'd0);
      check("cool count", 32'(req_count), 32'd8);

      // Reset on the second cycle of a warm request
      tick(2'b11, 1'b1, 1'b0);
      for (int k = 1; k <= 10; k++) tick(2'b10, 1'b1, 1'b0);
      tick(2'b11, 1'b1, 1'b0);
      check("rst pre req",   32'(hps_reset_req), 32'(3'b010));
      check("rst pre count", 32'(req_count),     32'd9);
      tick(2'b11, 1'b1, 1'b1);
      check("rst req",   32'(hps_reset_req), 32'd0);
      check("rst busy",  32'(busy),          32'd0);
      check("rst count", 32'(req_count),     32'd0);
      check("rst last",  32'(last_req),      32'd0);
      tick(2'b11, 1'b1, 1'b0);
      tick(2'b11, 1'b1, 1'b0);
      check("rst after req",  32'(hps_reset_req), 32'd0);
      check("rst after busy", 32'(busy),          32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
